// File: rtl/data_memory_responder_pkg.sv
// Shared encodings and helpers for the data memory responder and its byte RAM.
package data_memory_responder_pkg;

  localparam int unsigned DM_DEPTH = 512;
  localparam int unsigned DM_AW    = 9;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StDone   = 2'b10
  } dm_state_e;

  // Index of the last byte of an access (N-1).
  function automatic logic [1:0] last_idx(input logic [1:0] sz);
    unique case (sz)
      SZ_BYTE: last_idx = 2'd0;
      SZ_HALF: last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a_lo);
    unique case (sz)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = a_lo[0];
      SZ_WORD: misaligned = (a_lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_byte_ram.sv
// 512x8 byte store: synchronous write, asynchronous read, contents not reset.
module dm_byte_ram
  import data_memory_responder_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [DM_AW-1:0]   addr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata
);

  logic [7:0] mem [DM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_memory_responder.sv
// MEM-stage data memory responder: one byte per clock, big-endian lanes,
// sign/zero extension of loads, misalignment reported with done.
module data_memory_responder
  import data_memory_responder_pkg::*;
(
  input  logic        clk,
  input  logic        R_n,
  input  logic        E,
  input  logic        RW,
  input  logic [1:0]  size,
  input  logic        SE,
  input  logic [8:0]  A,
  input  logic [31:0] DI,
  output logic [31:0] DO,
  output logic        busy,
  output logic        done,
  output logic        err
);

  dm_state_e   state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic        rw_q, rw_d;
  logic [1:0]  size_q, size_d;
  logic        se_q, se_d;
  logic [8:0]  a_q, a_d;
  logic [31:0] di_q, di_d;
  logic        bad_q, bad_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] do_q, do_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [1:0]  lane;
  logic        ram_we;
  logic [8:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  // Big-endian: byte k of an N-byte access lands in lane N-1-k of the data word.
  assign lane      = last_idx(size_q) - k_q;
  assign ram_we    = (state_q == StAccess) && rw_q;
  assign ram_addr  = a_q + {7'b0, k_q};
  assign ram_wdata = di_q[{lane, 3'b000} +: 8];

  dm_byte_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    rw_d     = rw_q;
    size_d   = size_q;
    se_d     = se_q;
    a_d      = a_q;
    di_d     = di_q;
    bad_d    = bad_q;
    shadow_d = shadow_q;
    do_d     = do_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (E) begin
          rw_d     = RW;
          size_d   = size;
          se_d     = SE;
          a_d      = A;
          di_d     = DI;
          bad_d    = misaligned(size, A[1:0]);
          busy_d   = 1'b1;
          k_d      = 2'd0;
          shadow_d = '0;
          state_d  = misaligned(size, A[1:0]) ? StDone : StAccess;
        end
      end
      StAccess: begin
        if (!rw_q) begin
          shadow_d[{lane, 3'b000} +: 8] = ram_rdata;
        end
        if (k_q == last_idx(size_q)) begin
          state_d = StDone;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        err_d   = bad_q;
        k_d     = 2'd0;
        state_d = StIdle;
        if (!rw_q && !bad_q) begin
          unique case (size_q)
            SZ_BYTE: do_d = {{24{se_q & shadow_q[7]}}, shadow_q[7:0]};
            SZ_HALF: do_d = {{16{se_q & shadow_q[15]}}, shadow_q[15:0]};
            default: do_d = shadow_q;
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      state_q  <= StIdle;
      k_q      <= 2'd0;
      rw_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      se_q     <= 1'b0;
      a_q      <= '0;
      di_q     <= '0;
      bad_q    <= 1'b0;
      shadow_q <= '0;
      do_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      rw_q     <= rw_d;
      size_q   <= size_d;
      se_q     <= se_d;
      a_q      <= a_d;
      di_q     <= di_d;
      bad_q    <= bad_d;
      shadow_q <= shadow_d;
      do_q     <= do_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign DO   = do_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: stores, extended loads, errors,
// mid-access reset and back-to-back requests.
module tb_data_memory_responder;

  logic        clk;
  logic        R_n;
  logic        E;
  logic        RW;
  logic [1:0]  size;
  logic        SE;
  logic [8:0]  A;
  logic [31:0] DI;
  logic [31:0] DO;
  logic        busy;
  logic        done;
  logic        err;

  int checks;
  int failures;

  data_memory_responder dut (
    .clk  (clk),
    .R_n  (R_n),
    .E    (E),
    .RW   (RW),
    .size (size),
    .SE   (SE),
    .A    (A),
    .DI   (DI),
    .DO   (DO),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic rw, input logic [1:0] sz, input logic se,
                       input logic [8:0] addr, input logic [31:0] di);
    @(negedge clk);
    E    = 1'b1;
    RW   = rw;
    size = sz;
    SE   = se;
    A    = addr;
    DI   = di;
  endtask

  // Next posedge is the accept edge; counts cycles until done rises.
  task automatic finish(input string tag, input int lat, input logic exp_err,
                        input logic toggle, input logic drop);
    int cnt;
    @(posedge clk);
    #1;
    chk({tag, " busy_after_accept"}, 32'(busy), 32'd1);
    cnt = 0;
    while (!done && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
      if (!done) begin
        if (err !== 1'b0) chk({tag, " err_without_done"}, 32'(err), 32'd0);
        if (toggle) E = ~E;
      end
    end
    chk({tag, " latency"}, 32'(cnt), 32'(lat));
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " err"}, 32'(err), 32'(exp_err));
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    if (drop) E = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic rw, input logic [1:0] sz,
                        input logic se, input logic [8:0] addr, input logic [31:0] di,
                        input int lat, input logic exp_err);
    start(rw, sz, se, addr, di);
    finish(tag, lat, exp_err, 1'b0, 1'b1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    R_n  = 1'b0;
    E    = 1'b0;
    RW   = 1'b0;
    size = 2'b00;
    SE   = 1'b0;
    A    = '0;
    DI   = '0;

    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset DO", DO, 32'd0);
    @(negedge clk);
    R_n = 1'b1;

    // Word store, then load back.
    do_req("st_word", 1'b1, 2'b10, 1'b0, 9'h010, 32'h8421F00D, 5, 1'b0);
    chk("DO after store", DO, 32'd0);
    do_req("ld_word", 1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 5, 1'b0);
    chk("ld_word DO", DO, 32'h8421F00D);

    // Put 0x84 at 0x011, then byte loads with and without sign extension.
    do_req("st_byte", 1'b1, 2'b00, 1'b0, 9'h011, 32'h12345684, 2, 1'b0);
    chk("DO after st_byte", DO, 32'h8421F00D);
    do_req("ld_byte_se", 1'b0, 2'b00, 1'b1, 9'h011, 32'h0, 2, 1'b0);
    chk("ld_byte_se DO", DO, 32'hFFFFFF84);
    do_req("ld_byte_ze", 1'b0, 2'b00, 1'b0, 9'h011, 32'h0, 2, 1'b0);
    chk("ld_byte_ze DO", DO, 32'h00000084);

    do_req("ld_half_se", 1'b0, 2'b01, 1'b1, 9'h012, 32'h0, 3, 1'b0);
    chk("ld_half_se DO", DO, 32'hFFFFF00D);
    do_req("ld_half_ze", 1'b0, 2'b01, 1'b0, 9'h012, 32'h0, 3, 1'b0);
    chk("ld_half_ze DO", DO, 32'h0000F00D);

    // Errored requests complete in one cycle and touch neither array nor DO.
    do_req("st_word_mis", 1'b1, 2'b10, 1'b0, 9'h013, 32'hDEADBEEF, 1, 1'b1);
    chk("DO after mis", DO, 32'h0000F00D);
    do_req("st_illegal", 1'b1, 2'b11, 1'b0, 9'h010, 32'hDEADBEEF, 1, 1'b1);
    do_req("ld_half_mis", 1'b0, 2'b01, 1'b1, 9'h011, 32'h0, 1, 1'b1);
    chk("DO after ld mis", DO, 32'h0000F00D);
    do_req("ld_word_chk", 1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 5, 1'b0);
    chk("array after errs", DO, 32'h8484F00D);

    // Reset after two ACCESS cycles of a word store.
    do_req("st_pre", 1'b1, 2'b10, 1'b0, 9'h020, 32'h11223344, 5, 1'b0);
    start(1'b1, 2'b10, 1'b0, 9'h020, 32'hAABBCCDD);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    R_n = 1'b0;
    #1;
    chk("rst_mid busy", 32'(busy), 32'd0);
    chk("rst_mid done", 32'(done), 32'd0);
    chk("rst_mid DO", DO, 32'd0);
    E = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid done held", 32'(done), 32'd0);
    @(negedge clk);
    R_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid no done", 32'(done), 32'd0);
    do_req("ld_after_rst", 1'b0, 2'b10, 1'b0, 9'h020, 32'h0, 5, 1'b0);
    chk("partial store", DO, 32'hAABB3344);

    // Back-to-back with E held across done and toggled during ACCESS.
    start(1'b0, 2'b00, 1'b0, 9'h011, 32'h0);
    finish("b2b_first", 2, 1'b0, 1'b1, 1'b0);
    chk("b2b_first DO", DO, 32'h00000084);
    E    = 1'b1;
    size = 2'b01;
    SE   = 1'b1;
    A    = 9'h012;
    finish("b2b_second", 3, 1'b0, 1'b1, 1'b1);
    chk("b2b_second DO", DO, 32'hFFFFF00D);
    @(posedge clk);
    #1;
    chk("idle after b2b busy", 32'(busy), 32'd0);
    chk("idle after b2b done", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 R_n  input  1  reset, asynchronous assert, active-low.
REQ-004 E  input  1  access request from MEM stage (E_mem).
REQ-005 RW  input  1  1=write (store), 0=read (load) (rw_dm_mem).
REQ-006 size  input  2  00=byte, 01=halfword, 10=word, 11=illegal (size_mem).
REQ-007 SE  input  1  sign-extend loaded byte/halfword when 1 (se_mem).
REQ-008 A  input  9  byte address (alu_out_mem[8:0]).
REQ-009 DI  input  32  store data (df_a_mem).
REQ-010 DO  output  32  load result, extended to 32 bits.
REQ-011 busy  output  1  registered; high while a request is in progress.
REQ-012 done  output  1  registered; one-cycle completion pulse.
REQ-013 err  output  1  registered; valid with done; misaligned or illegal size.

Function
REQ-014 SHALL hold a 512x8 byte store and access exactly one byte per clk.
REQ-015 SHALL implement FSM IDLE, ACCESS, DONE.
REQ-016 IDLE: E=1 latches RW, size, SE, A, DI; busy<=1; goes to ACCESS with byte counter k=0.
REQ-017 IDLE: E=1 with misalignment goes to DONE, no array change; err=1 in DONE. Misalignment is size=01 with A[0]=1, size=10 with A[1:0]!=0, or size=11.
REQ-018 ACCESS: handles byte k at address A+k; leaves after N-1 (N=1/2/4 for byte/half/word), then goes to DONE.
REQ-019 Byte order is big-endian.
  - Word: byte k maps to DI/DO bits [31-8k:24-8k].
  - Halfword: bytes 0,1 map to bits [15:8],[7:0].
  - Byte: maps to bits [7:0].
REQ-020 Write: the byte is written at the clk edge ending that ACCESS cycle.
REQ-021 Read: bytes are assembled into a shadow register.
REQ-022 DONE: done=1 for exactly one cycle; busy<=0; next state IDLE.
  - Read with err=0: DO<=extended shadow value in the cycle done rises.
  - Byte extension: SE=1 replicates bit 7, else zero.
  - Halfword extension: SE=1 replicates bit 15, else zero.
REQ-023 DO holds its value until the next successful read completes; writes and errored requests do not change DO.
REQ-024 E is ignored in ACCESS and DONE; the requester holds E until done, then drops it.
REQ-025 An E still high in IDLE after DONE is a new request.
REQ-026 Latency from the accept edge to done high:
  - byte: 2 cycles
  - halfword: 3 cycles
  - word: 5 cycles
  - misaligned/illegal: 1 cycle
REQ-027 err SHALL be 0 whenever done=0.
REQ-028 A+k SHALL NOT wrap, since aligned accesses stay within the block; 9-bit addition SHALL still be used.

Reset
REQ-029 R_n=0 asynchronously forces state=IDLE, k=0, busy=0, done=0, err=0, DO=0, shadow=0.
REQ-030 Array contents SHALL NOT be cleared by reset.
REQ-031 Reset mid-ACCESS aborts the request; bytes already written remain; no done is issued.
REQ-032 The first accept is possible on the first clk edge after R_n rises.

Structure
REQ-033 Shared package SHALL hold:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state encoding
  - DM_DEPTH=512, DM_AW=9
REQ-034 Sub-module dm_byte_ram: 512x8, synchronous write, asynchronous read, ports clk/we/addr/wdata/rdata.
REQ-035 FSM, counter, lane steering and extension SHALL live in data_memory_responder.

Verification
REQ-036 Word store then load:
  - Store A=0x010, DI=0x8421F00D.
  - Bytes 0x010..0x013 = 84,21,F0,0D; done 5 cycles after accept.
  - Load word A=0x010 gives DO=0x8421F00D.
REQ-037 Byte load from address 0x011 holding 0x84:
  - SE=1 gives DO=0xFFFFFF84.
  - SE=0 gives DO=0x00000084.
  - Both at 2-cycle latency.
REQ-038 Halfword load at A=0x012 (bytes F0,0D):
  - SE=1 gives DO=0xFFFFF00D.
  - SE=0 gives DO=0x0000F00D.
REQ-039 Misaligned and illegal requests:
  - Word store A=0x013 gives done=1, err=1 one cycle after accept; array and DO unchanged.
  - size=11 gives the same response.
REQ-040 Reset mid-access:
  - Word store A=0x020, DI=0xAABBCCDD; pull R_n low after 2 ACCESS cycles.
  - busy=0 immediately, no done pulse.
  - 0x020=AA, 0x021=BB, 0x022/0x023 unchanged.
REQ-041 Back-to-back requests:
  - Hold E high across DONE.
  - Second request is accepted in the following IDLE cycle.
  - Pulses toggling E during ACCESS are ignored.
